// File: rtl/basemux_arbiter.sv
// Round-robin arbiter plus registered 2:1 mux stage for two valid/ready producers.
// Optional per-channel saturating grant counters when BASEMUX_ARB_STATS_EN is defined.
module basemux_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             select,
`ifdef BASEMUX_ARB_STATS_EN
   output logic [15:0]      grant_count_a,
   output logic [15:0]      grant_count_b,
`endif
   input  logic             out_ready
);

   localparam int unsigned CNT_W = 16;

   typedef enum logic {
      PRI_A = 1'b0,
      PRI_B = 1'b1
   } pri_e;

   pri_e             state_q, state_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             select_q, select_d;
   logic             load;
   logic             win_a;
   logic             win_b;
   logic             grant;

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= PRI_A;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         select_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         select_q    <= select_d;
      end
   end

   // Winner selection, next state and next output word
   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      select_d    = select_q;
      win_a       = 1'b0;
      win_b       = 1'b0;
      load        = !out_valid_q || out_ready;

      case (state_q)
         PRI_A: begin
            if (a_valid)      win_a = 1'b1;
            else if (b_valid) win_b = 1'b1;
         end
         PRI_B: begin
            if (b_valid)      win_b = 1'b1;
            else if (a_valid) win_a = 1'b1;
         end
         default: begin
            win_a = 1'b0;
            win_b = 1'b0;
         end
      endcase

      grant = load && (win_a || win_b);

      if (load) begin
         if (grant) begin
            out_data_d  = win_b ? b_data : a_data;
            select_d    = win_b;
            out_valid_d = 1'b1;
            state_d     = win_a ? PRI_B : PRI_A;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // Readies are forced low while reset is held, since load is high then
   assign a_ready   = !rst && load && win_a;
   assign b_ready   = !rst && load && win_b;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign select    = select_q;

`ifdef BASEMUX_ARB_STATS_EN
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end

   // Saturating grant counters
   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (load && win_a && (cnt_a_q != {CNT_W{1'b1}})) cnt_a_d = cnt_a_q + CNT_W'(1);
      if (load && win_b && (cnt_b_q != {CNT_W{1'b1}})) cnt_b_d = cnt_b_q + CNT_W'(1);
   end

   assign grant_count_a = cnt_a_q;
   assign grant_count_b = cnt_b_q;
`endif

endmodule

// File: doc/basemux_arbiter.md
# basemux_arbiter

Round-robin arbiter and output register that drives the select decision of the 32-bit 2:1 `basemux` and registers its result. Two valid/ready producer channels (`a`, `b`) compete for one registered valid/ready output. The data path follows `basemux` semantics: `select = 0` passes `a`, `select = 1` passes `b`. It sits directly upstream of the mux select line and directly downstream of the mux output, so the pair forms one pipeline stage.

## Interface
- `WIDTH`, default 32: data width of both inputs and the output.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `a_data`  in  WIDTH  channel A payload (mux input `a`).
- `a_valid`  in  1  channel A has data.
- `a_ready`  out  1  channel A transfer accepted this cycle.
- `b_data`  in  WIDTH  channel B payload (mux input `b`).
- `b_valid`  in  1  channel B has data.
- `b_ready`  out  1  channel B transfer accepted this cycle.
- `out_data`  out  WIDTH  registered mux result.
- `out_valid`  out  1  `out_data` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts `out_data`.
- `select`  out  1  registered select of the word in `out_data` (0 = from A, 1 = from B).
- `grant_count_a`, `grant_count_b`  out  16 each  present only with `BASEMUX_ARB_STATS_EN`.

## Operation
- Load enable: `load = !out_valid || out_ready`.
- Priority FSM with two states, reset state PRI_A:
  - PRI_A: A wins if `a_valid`; otherwise B wins if `b_valid`.
  - PRI_B: B wins if `b_valid`; otherwise A wins if `a_valid`.
  - After any accepted grant, the state moves to the opposite of the winner: win A goes to PRI_B, win B goes to PRI_A.
  - With no grant, the state holds.
- Ready outputs:
  - `a_ready = load && win_a`.
  - `b_ready = load && win_b`.
  - At most one ready is high per cycle.
  - A ready never rises without the matching valid.
- On a grant, the following register in the same edge:
  - `out_data <= win_b ? b_data : a_data`.
  - `select <= win_b`.
  - `out_valid <= 1`.
- If `load` is high and there is no grant: `out_valid <= 0`; `out_data` and `select` hold.
- If `load` is low: all output registers and the FSM hold, and both readies are 0.
- Producers must hold data stable while valid is high and ready is low. The block does not check this.

## Timing
- Reset values:
  - `out_valid = 0`, `out_data = 0`, `select = 0`.
  - FSM = PRI_A.
  - Both counters = 0.
  - `a_ready = b_ready = 0` while `rst` is high.
- Latency: input accepted at edge N appears on `out_data`/`out_valid` after edge N, i.e. 1 cycle.
- Throughput: 1 word per cycle while `out_ready` is held high.
- Readies depend combinationally on `out_ready` and the valids. There is no combinational path from data to ready.
- Both valid continuously with `out_ready = 1`: grants strictly alternate A, B, A, B…
- Backpressure (`out_ready = 0` with `out_valid = 1`): the output word is held unchanged and the FSM does not advance.
- Reset asserted mid-transfer: the in-flight output word is dropped and every register returns to its reset value asynchronously.

## Configuration
- `BASEMUX_ARB_STATS_EN` defined:
  - Adds `grant_count_a` and `grant_count_b`.
  - Each counter increments on every accepted grant to its channel.
  - Counters saturate at 16'hFFFF and clear only on `rst`.
- `BASEMUX_ARB_STATS_EN` undefined:
  - Counter ports and logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst = 1` with both valids high. Expect `out_valid = 0`, `out_data = 0`, `select = 0`, `a_ready = b_ready = 0`.
- Single channel: `a_data = 1`, `a_valid = 1`, `b_valid = 0`, `out_ready = 1`. One cycle later expect `out_data = 1`, `select = 0`. Then drive only B with `b_data = 0`; one cycle later expect `out_data = 0`, `select = 1`.
- Fairness: both valid, `a_data = 32'hAAAA_AAAA`, `b_data = 32'h5555_5555`, `out_ready = 1` for 6 cycles. Expect outputs in the order A, B, A, B, A, B, with `select` toggling 0, 1, 0, 1, 0, 1.
- Backpressure: after one grant, drop `out_ready` for 3 cycles. Expect `out_data` stable, both readies 0, and the FSM unchanged. On release, the next grant goes to the other channel.
- Mid-operation reset: pulse `rst` between clock edges while `out_valid = 1`. Expect `out_valid` to go to 0 immediately and the first grant after release to go to A.
- Stats (with the macro defined): 70000 cycles of A-only traffic. Expect `grant_count_a = 16'hFFFF` (saturated) and `grant_count_b = 0`.
